ex_muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide unit in the execute stage, directly downstream of the ID/EX pipeline register. It accepts a decoded M-extension operation together with forwarded operand values. It stalls the front of the pipeline while it iterates, then presents a one-cycle result to the EX/MEM path. It is a radix-2 sequential design: one result bit per cycle, no hardware multiplier array.

---
 rtl/muldiv_pkg.sv | 35 +++
 rtl/muldiv_iter_core.sv | 87 ++++++++
 rtl/ex_muldiv_unit.sv | 167 ++++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M iterative multiply/divide unit:
// funct3 decodes, the M-extension funct7 and the FSM state encoding.
package muldiv_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [6:0] M_EXT_FUNCT7 = 7'b0000001;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  function automatic logic f3_is_div(input logic [2:0] f3);
    return f3[2];
  endfunction

  // rs1 is treated as signed by everything except the fully unsigned ops
  function automatic logic f3_rs1_signed(input logic [2:0] f3);
    return (f3 != F3_MULHU) && (f3 != F3_DIVU) && (f3 != F3_REMU);
  endfunction

  function automatic logic f3_rs2_signed(input logic [2:0] f3);
    return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// Radix-2 iteration datapath: shared hi/lo shift register, one adder-subtractor
// and the iteration counter. Works purely on unsigned magnitudes.
module muldiv_iter_core
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic            step_i,
  input  logic            is_div_i,
  input  logic [XLEN-1:0] opnd_i,
  input  logic [XLEN-1:0] shift_i,
  output logic [XLEN-1:0] hi_next_o,
  output logic [XLEN-1:0] lo_next_o,
  output logic            last_o
);

  localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;
  localparam int AW = XLEN + 2;

  logic [XLEN-1:0] opnd_q;
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [CW-1:0]   cnt_q;

  logic [AW-1:0] add_a, add_b, sum;
  logic          add_cin;

  // Multiply adds the multiplicand into hi when lo[0] is set; divide subtracts
  // the divisor from {hi, next dividend bit}. The top bit of sum is the borrow.
  always_comb begin
    add_a   = {2'b00, hi_q};
    add_b   = '0;
    add_cin = 1'b0;
    if (is_div_i) begin
      add_a   = {1'b0, hi_q, lo_q[XLEN-1]};
      add_b   = ~{2'b00, opnd_q};
      add_cin = 1'b1;
    end else if (lo_q[0]) begin
      add_b = {2'b00, opnd_q};
    end
    sum = add_a + add_b + AW'(add_cin);
  end

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (is_div_i) begin
      if (!sum[AW-1]) begin
        hi_d = sum[XLEN-1:0];
        lo_d = {lo_q[XLEN-2:0], 1'b1};
      end else begin
        hi_d = add_a[XLEN-1:0];
        lo_d = {lo_q[XLEN-2:0], 1'b0};
      end
    end else begin
      hi_d = sum[XLEN:1];
      lo_d = {sum[0], lo_q[XLEN-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      opnd_q <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      cnt_q  <= '0;
    end else if (load_i) begin
      opnd_q <= opnd_i;
      hi_q   <= '0;
      lo_q   <= shift_i;
      cnt_q  <= '0;
    end else if (step_i) begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // Next-state values let the top capture the result on the final step edge
  assign hi_next_o = hi_d;
  assign lo_next_o = lo_d;
  assign last_o    = (cnt_q == CW'(XLEN - 1));

endmodule

// File: rtl/ex_muldiv_unit.sv
// Execute-stage RV32M multiply/divide unit: FSM, special-case divide handling,
// operand magnitude/sign handling, result sign fix and pipeline stall.
module ex_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] rs1_val_i,
  input  logic [XLEN-1:0] rs2_val_i,
  input  logic [4:0]      rd_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            busy_o,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_o
);

  localparam int DW = 2 * XLEN;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  function automatic logic [XLEN-1:0] negate(input logic [XLEN-1:0] v);
    return ~v + XLEN'(1);
  endfunction

  md_state_e state_q, state_d;

  logic [2:0]      funct3_q;
  logic [4:0]      rd_q;
  logic            sign1_q, sign2_q;
  logic [XLEN-1:0] result_q, result_d;
  logic [4:0]      rd_out_q;

  logic            accept, load, step, res_load;
  logic            rs1_neg, rs2_neg;
  logic [XLEN-1:0] mag1, mag2;
  logic            div_by_zero, div_ovf, special;
  logic [XLEN-1:0] special_res, fixed_res;
  logic [XLEN-1:0] core_hi, core_lo;
  logic            core_last;
  logic [DW-1:0]   prod, prod_fix;
  logic [XLEN-1:0] quot, rem;

  // Operand decode for the op sitting in ID/EX
  always_comb begin
    rs1_neg     = f3_rs1_signed(funct3_i) & rs1_val_i[XLEN-1];
    rs2_neg     = f3_rs2_signed(funct3_i) & rs2_val_i[XLEN-1];
    mag1        = rs1_neg ? negate(rs1_val_i) : rs1_val_i;
    mag2        = rs2_neg ? negate(rs2_val_i) : rs2_val_i;
    div_by_zero = f3_is_div(funct3_i) && (rs2_val_i == '0);
    div_ovf     = ((funct3_i == F3_DIV) || (funct3_i == F3_REM)) &&
                  (rs1_val_i == MIN_NEG) && (rs2_val_i == '1);
    special     = div_by_zero || div_ovf;
    // funct3[1] separates REM/REMU from DIV/DIVU
    if (div_by_zero) begin
      special_res = funct3_i[1] ? rs1_val_i : '1;
    end else begin
      special_res = funct3_i[1] ? '0 : MIN_NEG;
    end
  end

  always_comb begin
    prod     = {core_hi, core_lo};
    prod_fix = (sign1_q ^ sign2_q) ? (~prod + DW'(1)) : prod;
    quot     = (sign1_q ^ sign2_q) ? negate(core_lo) : core_lo;
    rem      = sign1_q ? negate(core_hi) : core_hi;
    case (funct3_q)
      F3_MUL:                       fixed_res = prod_fix[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: fixed_res = prod_fix[DW-1:XLEN];
      F3_DIV, F3_DIVU:              fixed_res = quot;
      default:                      fixed_res = rem;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= MD_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    load     = 1'b0;
    step     = 1'b0;
    res_load = 1'b0;
    result_d = fixed_res;
    case (state_q)
      MD_IDLE: begin
        if (start_i && !flush_i) begin
          accept = 1'b1;
          load   = 1'b1;
          if (special) begin
            state_d  = MD_DONE;
            res_load = 1'b1;
            result_d = special_res;
          end else begin
            state_d = MD_RUN;
          end
        end
      end
      MD_RUN: begin
        if (flush_i) begin
          state_d = MD_IDLE;
        end else begin
          step = 1'b1;
          if (core_last) begin
            state_d  = MD_DONE;
            res_load = 1'b1;
          end
        end
      end
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      funct3_q <= '0;
      rd_q     <= '0;
      sign1_q  <= 1'b0;
      sign2_q  <= 1'b0;
      result_q <= '0;
      rd_out_q <= '0;
    end else begin
      if (accept) begin
        funct3_q <= funct3_i;
        rd_q     <= rd_i;
        sign1_q  <= rs1_neg;
        sign2_q  <= rs2_neg;
      end
      if (res_load) begin
        result_q <= result_d;
        rd_out_q <= accept ? rd_i : rd_q;
      end
    end
  end

  muldiv_iter_core #(
    .XLEN(XLEN)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .load_i    (load),
    .step_i    (step),
    .is_div_i  (funct3_q[2]),
    .opnd_i    (f3_is_div(funct3_i) ? mag2 : mag1),
    .shift_i   (f3_is_div(funct3_i) ? mag1 : mag2),
    .hi_next_o (core_hi),
    .lo_next_o (core_lo),
    .last_o    (core_last)
  );

  // Gated by reset so a held ID/EX op cannot stall the pipe while in reset
  assign stall_o  = rst & (accept | (state_q == MD_RUN));
  assign busy_o   = (state_q != MD_IDLE);
  assign valid_o  = (state_q == MD_DONE) & ~flush_i;
  assign result_o = result_q;
  assign rd_o     = rd_out_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: directed RV32M cases plus randomized ops
// checked against a plain-arithmetic reference model.
module tb_ex_muldiv_unit;
  import muldiv_pkg::*;

  localparam int XLEN = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i, flush_i;
  logic [2:0]  funct3_i;
  logic [31:0] rs1_val_i, rs2_val_i;
  logic [4:0]  rd_i;
  logic        stall_o, busy_o, valid_o;
  logic [31:0] result_o;
  logic [4:0]  rd_o;

  typedef struct {
    logic [31:0] result;
    logic [4:0]  rd;
    int          cyc;
  } exp_t;

  exp_t expQ[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  ex_muldiv_unit #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_i),
    .funct3_i  (funct3_i),
    .rs1_val_i (rs1_val_i),
    .rs2_val_i (rs2_val_i),
    .rd_i      (rd_i),
    .flush_i   (flush_i),
    .stall_o   (stall_o),
    .busy_o    (busy_o),
    .valid_o   (valid_o),
    .result_o  (result_o),
    .rd_o      (rd_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
    end
  endtask

  // RV32M semantics from plain 64-bit arithmetic; SV '/' and '%' truncate like RISC-V
  function automatic logic [31:0] refModel(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] b);
    longint      sa, sb, ub;
    logic [63:0] p;
    logic [31:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'd0, b});
    p  = '0;
    r  = '0;
    case (f3)
      F3_MUL:    begin p = sa * sb; r = p[31:0]; end
      F3_MULH:   begin p = sa * sb; r = p[63:32]; end
      F3_MULHSU: begin p = sa * ub; r = p[63:32]; end
      F3_MULHU:  begin p = {32'd0, a} * {32'd0, b}; r = p[63:32]; end
      F3_DIV:    begin p = sa / ((b == 0) ? 64'sd1 : sb); r = (b == 0) ? 32'hFFFF_FFFF : p[31:0]; end
      F3_DIVU:   r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      F3_REM:    begin p = sa % ((b == 0) ? 64'sd1 : sb); r = (b == 0) ? a : p[31:0]; end
      default:   r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic int refLatency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    bit ovf;
    ovf = ((f3 == F3_DIV) || (f3 == F3_REM)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    return (f3[2] && ((b == 0) || ovf)) ? 1 : XLEN + 1;
  endfunction

  // Presents one op in ID/EX, holding it while stall_o is high like the pipeline would
  task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] rd, input logic [31:0] expResult);
    exp_t e;
    int   lat, stallCnt, guard;
    @(negedge clk);
    start_i   = 1'b1;
    funct3_i  = f3;
    rs1_val_i = a;
    rs2_val_i = b;
    rd_i      = rd;
    lat       = refLatency(f3, a, b);
    e.result  = expResult;
    e.rd      = rd;
    e.cyc     = cyc + lat;
    expQ.push_back(e);
    #1;
    stallCnt = 0;
    guard    = 0;
    while (stall_o === 1'b1 && guard < 200) begin
      stallCnt++;
      guard++;
      @(negedge clk);
      #1;
    end
    start_i = 1'b0;
    checkOutput("stallCycles", 32'(stallCnt), 32'(lat));
  endtask

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: every valid_o must match the oldest outstanding expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (valid_o === 1'b1) begin
        if (expQ.size() == 0) begin
          checkOutput("strayValid", 32'd1, 32'd0);
        end else begin
          e = expQ.pop_front();
          checkOutput("result", result_o, e.result);
          checkOutput("rd", 32'(rd_o), 32'(e.rd));
          checkOutput("validCycle", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] a, b;
    logic [2:0]  f3;
    rst       = 1'b0;
    start_i   = 1'b0;
    flush_i   = 1'b0;
    funct3_i  = '0;
    rs1_val_i = '0;
    rs2_val_i = '0;
    rd_i      = '0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("resetBusy", 32'(busy_o), 32'd0);
    checkOutput("resetValid", 32'(valid_o), 32'd0);
    checkOutput("resetResult", result_o, 32'd0);
    checkOutput("resetRd", 32'(rd_o), 32'd0);
    checkOutput("resetStall", 32'(stall_o), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    applyStimulus(F3_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 5'd1, 32'hFFFF_FFEB);
    applyStimulus(F3_MULH,   32'h8000_0000, 32'hFFFF_FFFF, 5'd2, 32'h0000_0000);
    applyStimulus(F3_MULHSU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd3, 32'h8000_0000);
    applyStimulus(F3_MULHU,  32'h8000_0000, 32'hFFFF_FFFF, 5'd4, 32'h7FFF_FFFF);
    applyStimulus(F3_DIV,    32'hFFFF_FFF9, 32'd2,         5'd5, 32'hFFFF_FFFD);
    applyStimulus(F3_REM,    32'hFFFF_FFF9, 32'd2,         5'd6, 32'hFFFF_FFFF);
    applyStimulus(F3_DIVU,   32'd100,       32'd7,         5'd7, 32'd14);
    applyStimulus(F3_REMU,   32'd100,       32'd7,         5'd8, 32'd2);
    applyStimulus(F3_DIVU,   32'd5,         32'd0,         5'd9, 32'hFFFF_FFFF);
    applyStimulus(F3_REM,    32'd5,         32'd0,         5'd10, 32'd5);
    applyStimulus(F3_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000);
    applyStimulus(F3_REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h0000_0000);

    // Flush in IDLE must block acceptance
    @(negedge clk);
    start_i  = 1'b1;
    flush_i  = 1'b1;
    funct3_i = F3_MUL;
    #1;
    checkOutput("stallFlushIdle", 32'(stall_o), 32'd0);
    @(negedge clk);
    start_i = 1'b0;
    flush_i = 1'b0;
    #1;
    checkOutput("busyFlushIdle", 32'(busy_o), 32'd0);

    // Kill an op at RUN cycle 10, then a fresh MUL must complete normally
    @(negedge clk);
    start_i   = 1'b1;
    funct3_i  = F3_MUL;
    rs1_val_i = 32'd123456;
    rs2_val_i = 32'd789;
    rd_i      = 5'd20;
    @(negedge clk);
    start_i = 1'b0;
    repeat (9) @(negedge clk);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    #1;
    checkOutput("busyAfterFlush", 32'(busy_o), 32'd0);
    applyStimulus(F3_MUL, 32'd3, 32'd4, 5'd21, 32'd12);

    // Reset in the middle of RUN abandons the op at once
    @(negedge clk);
    start_i   = 1'b1;
    funct3_i  = F3_DIVU;
    rs1_val_i = 32'hDEAD_BEEF;
    rs2_val_i = 32'd3;
    rd_i      = 5'd25;
    repeat (5) @(negedge clk);
    #1;
    checkOutput("busyBeforeReset", 32'(busy_o), 32'd1);
    rst = 1'b0;
    #1;
    checkOutput("rstBusy", 32'(busy_o), 32'd0);
    checkOutput("rstValid", 32'(valid_o), 32'd0);
    checkOutput("rstResult", result_o, 32'd0);
    checkOutput("rstRd", 32'(rd_o), 32'd0);
    checkOutput("rstStall", 32'(stall_o), 32'd0);
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    #1;
    checkOutput("idleAfterReset", 32'(busy_o), 32'd0);

    for (int i = 0; i < 40; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = pickOperand();
      b  = pickOperand();
      applyStimulus(f3, a, b, 5'($urandom_range(1, 31)), refModel(f3, a, b));
    end

    repeat (4) @(negedge clk);
    checkOutput("pendingResults", 32'(expQ.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
